pgr_uart_cmd_dispatch: RTL and testbench

Parametrised command dispatcher between the UART command parser and NCH bus-master channels (APB, MDIO, I2C, …). It latches each parsed command's target channel, issues a one-cycle start to that channel, and returns its response bytes to the UART TX FIFO. A per-command watchdog aborts a hung channel, emits an error byte and completes the handshake, so the parser can never deadlock. It generalises the fixed two-target APB/MDIO select to N channels, with registered handshakes and error accounting.

---
 rtl/pgr_uart_cmd_pkg.sv | 14 +
 rtl/pgr_uart_cmd_dispatch_if.sv | 59 +++++
 rtl/pgr_uart_cmd_timer.sv | 32 +++
 rtl/pgr_uart_cmd_dispatch.sv | 158 +++++++++++++++
 tb/tb_pgr_uart_cmd_dispatch.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pgr_uart_cmd_pkg.sv
// pgr_uart_cmd_pkg: shared types for the UART
// command dispatcher and its watchdog.
package pgr_uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ERR_TX,
        DONE
    } state_t;

    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/pgr_uart_cmd_dispatch_if.sv
// pgr_uart_cmd_dispatch_if: parser, channel and
// TX FIFO signals seen by the command dispatcher.
interface pgr_uart_cmd_dispatch_if #(
    parameter int AW  = 24,
    parameter int NCH = 4
);
    logic               uart_ctrl_sel;
    logic [AW-1:0]      cmd_addr;
    logic               cmd_en;
    logic               cmd_done;
    logic               uart_match;
    logic               busy;
    logic [NCH-1:0]     ch_cmd_en;
    logic [NCH-1:0]     ch_cmd_done;
    logic [NCH-1:0]     ch_abort;
    logic [8*NCH-1:0]   ch_tx_data;
    logic [NCH-1:0]     ch_tx_req;
    logic [7:0]         tx_fifo_wr_data;
    logic               tx_fifo_wr_data_req;
    logic               tx_fifo_wr_data_valid;
    logic [15:0]        err_cnt;

    modport master (
        input  uart_ctrl_sel,
        input  cmd_addr,
        input  cmd_en,
        output cmd_done,
        output uart_match,
        output busy,
        output ch_cmd_en,
        input  ch_cmd_done,
        output ch_abort,
        input  ch_tx_data,
        input  ch_tx_req,
        output tx_fifo_wr_data,
        output tx_fifo_wr_data_req,
        input  tx_fifo_wr_data_valid,
        output err_cnt
    );

    modport slave (
        output uart_ctrl_sel,
        output cmd_addr,
        output cmd_en,
        input  cmd_done,
        input  uart_match,
        input  busy,
        input  ch_cmd_en,
        output ch_cmd_done,
        input  ch_abort,
        output ch_tx_data,
        output ch_tx_req,
        input  tx_fifo_wr_data,
        input  tx_fifo_wr_data_req,
        output tx_fifo_wr_data_valid,
        input  err_cnt
    );

endinterface

// File: rtl/pgr_uart_cmd_timer.sv
// pgr_uart_cmd_timer: per-command watchdog that
// counts up to TIMEOUT_CYC and holds there.
module pgr_uart_cmd_timer #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW =
        (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYC);

    logic [TW-1:0] cnt;

    // clear (reload to zero) beats counting; never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LIM) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYC != 0) && (cnt == LIM);

endmodule

// File: rtl/pgr_uart_cmd_dispatch.sv
// pgr_uart_cmd_dispatch: routes each parsed command to
// one of NCH channels and returns its TX bytes.
module pgr_uart_cmd_dispatch
    import pgr_uart_cmd_pkg::*;
#(
    parameter int AW          = 24,
    parameter int NCH         = 4,
    parameter int SEL_LSB     = 24,
    parameter int SEL_W       = 4,
    parameter int ID_BIT      = 28,
    parameter int TIMEOUT_CYC = 1000000,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
    input logic clk,
    input logic rst,
    pgr_uart_cmd_dispatch_if.master bus
);

    // address is widened so the ID and select fields
    // always exist, even when they sit above AW
    localparam int XW0 =
        (AW > ID_BIT + 1) ? AW : ID_BIT + 1;
    localparam int XW =
        (XW0 > SEL_LSB + SEL_W) ? XW0 : SEL_LSB + SEL_W;
    localparam int SW1 = SEL_W + 1;
    localparam logic [SEL_W:0] NCH_L = SW1'(NCH);
    localparam logic [NCH-1:0] ONE = NCH'(1);

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [XW-1:0]    addr_x;
    logic [SEL_W-1:0] new_sel;
    logic             id_hit;
    logic             new_ok;
    logic [7:0]       mux_data;
    logic             mux_req;
    logic             mux_done;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_exp;
    logic             unused_addr;

    assign addr_x      = XW'(bus.cmd_addr);
    assign unused_addr = ^addr_x;
    assign new_sel     = addr_x[SEL_LSB +: SEL_W];
    assign id_hit      = addr_x[ID_BIT] == bus.uart_ctrl_sel;
    assign new_ok      = {1'b0, new_sel} < NCH_L;
    assign bus.busy    = state != IDLE;

    // select the latched channel's TX and done strobes
    always_comb begin
        mux_data = '0;
        mux_req  = 1'b0;
        mux_done = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_data = bus.ch_tx_data[8*k +: 8];
                mux_req  = bus.ch_tx_req[k];
                mux_done = bus.ch_cmd_done[k];
            end
        end
    end

    // TX FIFO port: pass-through in BUSY, error byte in ERR_TX
    always_comb begin
        bus.tx_fifo_wr_data     = '0;
        bus.tx_fifo_wr_data_req = 1'b0;
        unique case (state)
            BUSY: begin
                bus.tx_fifo_wr_data     = mux_data;
                bus.tx_fifo_wr_data_req = mux_req;
            end
            ERR_TX: begin
                if (bus.tx_fifo_wr_data_valid) begin
                    bus.tx_fifo_wr_data     = ERR_BYTE;
                    bus.tx_fifo_wr_data_req = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign tmr_en  = state == BUSY;
    assign tmr_clr = (state == IDLE && bus.cmd_en
                      && id_hit && new_ok)
                   || (state == BUSY && mux_req);

    pgr_uart_cmd_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_exp)
    );

    // command FSM with registered pulses and error count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sel            <= '0;
            bus.uart_match <= 1'b0;
            bus.ch_cmd_en  <= '0;
            bus.ch_abort   <= '0;
            bus.cmd_done   <= 1'b0;
            bus.err_cnt    <= '0;
        end else begin
            bus.ch_cmd_en <= '0;
            bus.ch_abort  <= '0;
            bus.cmd_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_en) begin
                        bus.uart_match <= id_hit;
                        sel            <= new_sel;
                        if (!id_hit) begin
                            state        <= DONE;
                            bus.cmd_done <= 1'b1;
                        end else if (new_ok) begin
                            bus.ch_cmd_en <= ONE << new_sel;
                            state         <= BUSY;
                        end else begin
                            bus.err_cnt <= bus.err_cnt
                                + 16'(bus.err_cnt != 16'hFFFF);
                            state <= ERR_TX;
                        end
                    end
                end
                BUSY: begin
                    if (mux_done) begin
                        state        <= DONE;
                        bus.cmd_done <= 1'b1;
                    end else if (tmr_exp) begin
                        bus.ch_abort <= ONE << sel;
                        bus.err_cnt  <= bus.err_cnt
                            + 16'(bus.err_cnt != 16'hFFFF);
                        state <= ERR_TX;
                    end
                end
                ERR_TX: begin
                    if (bus.tx_fifo_wr_data_valid) begin
                        state        <= DONE;
                        bus.cmd_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pgr_uart_cmd_dispatch.sv
// tb_pgr_uart_cmd_dispatch: randomized scenario bench
// for the UART command dispatcher.
module tb_pgr_uart_cmd_dispatch;

    localparam int AW  = 32;
    localparam int NCH = 4;
    localparam int TO  = 100;
    localparam logic [7:0] EB = 8'hEE;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pgr_uart_cmd_dispatch_if #(.AW(AW), .NCH(NCH)) bus();

    pgr_uart_cmd_dispatch #(
        .AW(AW), .NCH(NCH), .SEL_LSB(24), .SEL_W(4),
        .ID_BIT(28), .TIMEOUT_CYC(TO), .ERR_BYTE(EB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    byte unsigned   tx_q[$];
    int             tx_c[$];
    int             n_done, done_c, n_en, n_abort, abort_c;
    logic [NCH-1:0] en_v, abort_v;

    // event log sampled mid-cycle
    always @(negedge clk) begin
        if (bus.tx_fifo_wr_data_req === 1'b1) begin
            tx_q.push_back(bus.tx_fifo_wr_data);
            tx_c.push_back(cyc);
        end
        if (bus.cmd_done === 1'b1) begin
            n_done++;
            done_c = cyc;
        end
        if (|bus.ch_cmd_en === 1'b1) begin
            n_en++;
            en_v = bus.ch_cmd_en;
        end
        if (|bus.ch_abort === 1'b1) begin
            n_abort++;
            abort_c = cyc;
            abort_v = bus.ch_abort;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation hung at cyc=%0d", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        tx_q.delete();
        tx_c.delete();
        n_done = 0; done_c = -1;
        n_en = 0; en_v = '0;
        n_abort = 0; abort_c = -1; abort_v = '0;
    endtask

    function automatic logic [31:0] mk_addr(
        input logic id, input int s);
        logic [31:0] a;
        a = $urandom;
        a[28] = id;
        a[27:24] = s[3:0];
        return a;
    endfunction

    task automatic issue(input logic [31:0] a, output int t);
        bus.cmd_addr = a;
        bus.cmd_en = 1'b1;
        t = cyc;
        step();
        bus.cmd_en = 1'b0;
        bus.cmd_addr = $urandom;
    endtask

    task automatic test_reset();
        logic [60:0] obs;
        rst = 1'b1;
        repeat (3) step();
        obs = {bus.cmd_done, bus.busy, bus.uart_match,
               bus.ch_cmd_en, bus.ch_abort,
               bus.tx_fifo_wr_data_req, bus.tx_fifo_wr_data,
               bus.err_cnt};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_outs: got %h want 0", obs);
        end
        rst = 1'b0;
        exp_err = 0;
        step();
        total++;
        if (bus.busy !== 1'b0 || bus.err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_release: busy=%b err=%0d want 0/0",
                     bus.busy, bus.err_cnt);
        end
    endtask

    task automatic test_dispatch();
        for (int it = 0; it < 6; it++) begin
            int s, nb, o, t, u;
            logic id;
            byte unsigned d;
            byte unsigned exp_q[$];
            s  = (it == 0) ? 2 : $urandom_range(0, 3);
            nb = (it == 0) ? 4 : $urandom_range(1, 6);
            id = 1'($urandom_range(0, 1));
            clear_log();
            bus.uart_ctrl_sel = id;
            issue(mk_addr(id, s), t);
            total++;
            if (bus.ch_cmd_en !== (NCH'(1) << s)
                || bus.busy !== 1'b1
                || bus.uart_match !== 1'b1) begin
                bad++;
                $display("FAIL disp_start: en=%b busy=%b m=%b want en=%b 1 1",
                         bus.ch_cmd_en, bus.busy, bus.uart_match,
                         NCH'(1) << s);
            end
            for (int b = 0; b < nb; b++) begin
                d = (it == 0) ? 8'((b + 1) * 17) : 8'($urandom);
                o = (s + $urandom_range(1, 3)) % NCH;
                exp_q.push_back(d);
                bus.ch_tx_data = $urandom;
                bus.ch_tx_data[8*s +: 8] = d;
                bus.ch_tx_req = '0;
                bus.ch_tx_req[s] = 1'b1;
                bus.ch_tx_req[o] = 1'($urandom_range(0, 1));
                step();
                bus.ch_tx_req = '0;
                repeat ($urandom_range(0, 2)) step();
            end
            bus.ch_cmd_done[s] = 1'b1;
            u = cyc;
            step();
            bus.ch_cmd_done = '0;
            total++;
            if (bus.cmd_done !== 1'b1 || cyc != u + 1) begin
                bad++;
                $display("FAIL disp_done: cmd_done=%b want 1", bus.cmd_done);
            end
            step();
            total++;
            if (bus.cmd_done !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL disp_idle: done=%b busy=%b want 0 0",
                         bus.cmd_done, bus.busy);
            end
            total++;
            if (tx_q != exp_q) begin
                bad++;
                $display("FAIL disp_tx: got %p want %p", tx_q, exp_q);
            end
            total++;
            if (n_en != 1 || n_done != 1
                || bus.err_cnt !== 16'(exp_err)) begin
                bad++;
                $display("FAIL disp_cnt: en=%0d done=%0d err=%0d want 1 1 %0d",
                         n_en, n_done, bus.err_cnt, exp_err);
            end
        end
    endtask

    task automatic test_mismatch();
        for (int it = 0; it < 3; it++) begin
            int s, t;
            logic id;
            s  = $urandom_range(0, 15);
            id = 1'($urandom_range(0, 1));
            clear_log();
            bus.uart_ctrl_sel = ~id;
            issue(mk_addr(id, s), t);
            total++;
            if (bus.cmd_done !== 1'b1 || bus.uart_match !== 1'b0
                || bus.ch_cmd_en !== '0) begin
                bad++;
                $display("FAIL mism_done: done=%b m=%b en=%b want 1 0 0",
                         bus.cmd_done, bus.uart_match, bus.ch_cmd_en);
            end
            step();
            total++;
            if (bus.busy !== 1'b0 || tx_q.size() != 0
                || n_en != 0 || n_done != 1) begin
                bad++;
                $display("FAIL mism_after: busy=%b tx=%0d en=%0d done=%0d want 0 0 0 1",
                         bus.busy, tx_q.size(), n_en, n_done);
            end
        end
    endtask

    task automatic test_bad_channel();
        for (int it = 0; it < 2; it++) begin
            int s, t;
            s = (it == 0) ? 5 : $urandom_range(NCH, 15);
            clear_log();
            bus.uart_ctrl_sel = 1'b1;
            bus.tx_fifo_wr_data_valid = 1'b1;
            issue(mk_addr(1'b1, s), t);
            exp_err++;
            for (int i = 0; i < 20 && n_done == 0; i++) step();
            total++;
            if (n_done != 1) begin
                bad++;
                $display("FAIL badch_timeout: done count=%0d want 1", n_done);
            end else begin
                total++;
                if (tx_q.size() != 1 || tx_q[0] != EB
                    || tx_c[0] < t + 1 || done_c != tx_c[0] + 1) begin
                    bad++;
                    $display("FAIL badch_tx: n=%0d done_c=%0d t=%0d want one EE then done",
                             tx_q.size(), done_c, t);
                end
            end
            total++;
            if (n_en != 0 || n_abort != 0
                || bus.err_cnt !== 16'(exp_err)) begin
                bad++;
                $display("FAIL badch_cnt: en=%0d ab=%0d err=%0d want 0 0 %0d",
                         n_en, n_abort, bus.err_cnt, exp_err);
            end
        end
    endtask

    task automatic test_timeout(input int hold);
        int s, t;
        s = $urandom_range(0, 3);
        clear_log();
        bus.uart_ctrl_sel = 1'b0;
        issue(mk_addr(1'b0, s), t);
        while (cyc < t + 300 && n_done == 0) begin
            bus.tx_fifo_wr_data_valid = (cyc >= t + TO + 2 + hold);
            step();
        end
        bus.tx_fifo_wr_data_valid = 1'b1;
        exp_err++;
        total++;
        if (n_done != 1) begin
            bad++;
            $display("FAIL to_done(h=%0d): done count=%0d want 1", hold, n_done);
        end
        total++;
        if (n_abort != 1 || abort_c != t + TO + 2
            || abort_v !== (NCH'(1) << s)) begin
            bad++;
            $display("FAIL to_abort(h=%0d): n=%0d at=%0d v=%b want 1 %0d %b",
                     hold, n_abort, abort_c - t, abort_v, TO + 2,
                     NCH'(1) << s);
        end
        total++;
        if (tx_q.size() != 1 || tx_c.size() != 1) begin
            bad++;
            $display("FAIL to_tx(h=%0d): bytes=%0d want 1", hold, tx_q.size());
        end else if (tx_q[0] != EB || tx_c[0] != t + TO + 2 + hold
                     || done_c != t + TO + 3 + hold) begin
            bad++;
            $display("FAIL to_tx(h=%0d): byte=%h at=%0d done=%0d want EE %0d %0d",
                     hold, tx_q[0], tx_c[0] - t, done_c - t,
                     TO + 2 + hold, TO + 3 + hold);
        end
        total++;
        if (bus.err_cnt !== 16'(exp_err) || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL to_err(h=%0d): err=%0d busy=%b want %0d 0",
                     hold, bus.err_cnt, bus.busy, exp_err);
        end
    endtask

    task automatic test_done_on_expiry();
        int s, t, t2;
        s = $urandom_range(0, 3);
        clear_log();
        bus.uart_ctrl_sel = 1'b1;
        issue(mk_addr(1'b1, s), t);
        while (cyc < t + 5) step();
        issue(mk_addr(1'b1, (s + 1) % NCH), t2);
        while (cyc < t + TO + 1) step();
        bus.ch_cmd_done[s] = 1'b1;
        step();
        bus.ch_cmd_done = '0;
        total++;
        if (bus.cmd_done !== 1'b1 || bus.ch_abort !== '0) begin
            bad++;
            $display("FAIL exp_done: done=%b abort=%b want 1 0",
                     bus.cmd_done, bus.ch_abort);
        end
        step();
        total++;
        if (n_abort != 0 || tx_q.size() != 0 || n_done != 1
            || bus.err_cnt !== 16'(exp_err)) begin
            bad++;
            $display("FAIL exp_clean: ab=%0d tx=%0d done=%0d err=%0d want 0 0 1 %0d",
                     n_abort, tx_q.size(), n_done, bus.err_cnt, exp_err);
        end
        total++;
        if (n_en != 1 || en_v !== (NCH'(1) << s)) begin
            bad++;
            $display("FAIL exp_ignore2nd: en=%0d v=%b want 1 %b",
                     n_en, en_v, NCH'(1) << s);
        end
    endtask

    task automatic test_reset_busy();
        int s, t, u;
        logic [60:0] obs;
        s = $urandom_range(0, 3);
        clear_log();
        bus.uart_ctrl_sel = 1'b0;
        issue(mk_addr(1'b0, s), t);
        repeat (3) step();
        rst = 1'b1;
        #1;
        obs = {bus.cmd_done, bus.busy, bus.uart_match,
               bus.ch_cmd_en, bus.ch_abort,
               bus.tx_fifo_wr_data_req, bus.tx_fifo_wr_data,
               bus.err_cnt};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL rstbusy_outs: got %h want 0", obs);
        end
        step();
        rst = 1'b0;
        exp_err = 0;
        step();
        total++;
        if (n_abort != 0 || n_done != 0) begin
            bad++;
            $display("FAIL rstbusy_pulse: ab=%0d done=%0d want 0 0",
                     n_abort, n_done);
        end
        s = $urandom_range(0, 3);
        clear_log();
        issue(mk_addr(1'b0, s), t);
        step();
        bus.ch_cmd_done[s] = 1'b1;
        u = cyc;
        step();
        bus.ch_cmd_done = '0;
        step();
        total++;
        if (n_en != 1 || n_done != 1 || done_c != u + 1
            || bus.err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL rstbusy_next: en=%0d done=%0d err=%0d want 1 1 0",
                     n_en, n_done, bus.err_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.uart_ctrl_sel = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_en = 1'b0;
        bus.ch_cmd_done = '0;
        bus.ch_tx_data = '0;
        bus.ch_tx_req = '0;
        bus.tx_fifo_wr_data_valid = 1'b1;
        clear_log();
        test_reset();
        test_dispatch();
        test_mismatch();
        test_bad_channel();
        test_timeout(0);
        test_timeout(20);
        test_done_on_expiry();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
